// File: rtl/m68k_bus_pkg.sv
// m68k_bus_pkg: shared state encoding and constants for the 68000 bus sequencer
package m68k_bus_pkg;
   typedef enum logic [2:0] {IDLE, ADDR, STROBE, WAIT, DONE, RECOVER} state_t;
   localparam logic STROBE_OFF = 1'b1;
   function automatic int cnt_width(input int t);
      return t > 2 ? $clog2(t) : 1;
   endfunction
endpackage

// File: rtl/m68k_bus_sequencer_if.sv
// m68k_bus_sequencer_if: j68 request side plus 68000 pad side of the bus sequencer
interface m68k_bus_sequencer_if;
   logic        cpu_rd_ena;
   logic        cpu_wr_ena;
   logic [1:0]  cpu_byte_ena;
   logic [31:0] cpu_address;
   logic [15:0] cpu_wr_data;
   logic [15:0] cpu_rd_data;
   logic        cpu_data_ack;
   logic        cpu_bus_err;
   logic [22:0] bus_addr;
   logic [15:0] bus_data_out;
   logic        bus_data_oe;
   logic [15:0] bus_data_in;
   logic        ASn;
   logic        R_Wn;
   logic        UDSn;
   logic        LDSn;
   logic        DTACKn;
   logic        BERRn;
   modport slave (
      input  cpu_rd_ena, cpu_wr_ena, cpu_byte_ena, cpu_address, cpu_wr_data, bus_data_in, DTACKn, BERRn,
      output cpu_rd_data, cpu_data_ack, cpu_bus_err, bus_addr, bus_data_out, bus_data_oe, ASn, R_Wn, UDSn, LDSn
   );
   modport master (
      output cpu_rd_ena, cpu_wr_ena, cpu_byte_ena, cpu_address, cpu_wr_data, bus_data_in, DTACKn, BERRn,
      input  cpu_rd_data, cpu_data_ack, cpu_bus_err, bus_addr, bus_data_out, bus_data_oe, ASn, R_Wn, UDSn, LDSn
   );
endinterface

// File: rtl/m68k_bus_sequencer_sync.sv
// m68k_bus_sequencer_sync: W-bit multi-flop synchroniser; flops reset to 1 so active-low inputs start inactive
module m68k_bus_sequencer_sync #(
   parameter int STAGES = 2,
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [STAGES-1:0][W-1:0] r;
   always_ff @(posedge clk) r <= rst ? '1 : {r[STAGES-2:0], d};
   assign q = r[STAGES-1];
endmodule

// File: rtl/m68k_bus_sequencer.sv
// m68k_bus_sequencer: turns j68 synchronous requests into 68000 asynchronous bus cycles with a watchdog
module m68k_bus_sequencer
   import m68k_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int SYNC_STAGES = 2
) (
   input logic clk,
   input logic rst,
   m68k_bus_sequencer_if.slave bus
);
   localparam int CW = cnt_width(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
   state_t state;
   logic [CW-1:0] cnt;
   logic wr;
   logic [1:0] be;
   logic [1:0] sync_q;
   logic dtack_s, berr_s, resp, fail;
   m68k_bus_sequencer_sync #(.STAGES(SYNC_STAGES), .W(2)) u_sync (
      .clk(clk),
      .rst(rst),
      .d({bus.DTACKn, bus.BERRn}),
      .q(sync_q)
   );
   assign dtack_s = sync_q[1];
   assign berr_s = sync_q[0];
   // BERR outranks DTACK; a response-free exit is the watchdog and reports as an error
   assign resp = !berr_s || !dtack_s || cnt == LAST;
   assign fail = !berr_s || dtack_s;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         wr <= 1'b0;
         be <= 2'b00;
         bus.ASn <= STROBE_OFF;
         bus.UDSn <= STROBE_OFF;
         bus.LDSn <= STROBE_OFF;
         bus.R_Wn <= 1'b1;
         bus.bus_data_oe <= 1'b0;
         bus.cpu_data_ack <= 1'b0;
         bus.cpu_bus_err <= 1'b0;
         bus.cpu_rd_data <= '0;
         bus.bus_addr <= '0;
         bus.bus_data_out <= '0;
      end else begin
         bus.cpu_data_ack <= 1'b0;
         bus.cpu_bus_err <= 1'b0;
         case (state)
            IDLE: if (bus.cpu_rd_ena || bus.cpu_wr_ena) begin
               state <= ADDR;
               wr <= bus.cpu_wr_ena;
               be <= bus.cpu_byte_ena;
               bus.bus_addr <= bus.cpu_address[23:1];
               bus.bus_data_out <= bus.cpu_wr_data;
               bus.R_Wn <= !bus.cpu_wr_ena;
               bus.bus_data_oe <= bus.cpu_wr_ena && |bus.cpu_byte_ena;
            end
            ADDR: if (be == 2'b00) begin
               state <= DONE;
               bus.cpu_data_ack <= 1'b1;
               bus.cpu_rd_data <= '0;
            end else begin
               state <= STROBE;
               cnt <= '0;
               bus.ASn <= 1'b0;
               bus.UDSn <= wr || !be[1];
               bus.LDSn <= wr || !be[0];
            end
            // write data strobes trail ASn by one cycle so the pad data is settled
            STROBE: begin
               state <= WAIT;
               cnt <= cnt + 1'b1;
               bus.UDSn <= !be[1];
               bus.LDSn <= !be[0];
            end
            WAIT: begin
               cnt <= cnt + 1'b1;
               if (resp) begin
                  state <= DONE;
                  bus.ASn <= STROBE_OFF;
                  bus.UDSn <= STROBE_OFF;
                  bus.LDSn <= STROBE_OFF;
                  bus.cpu_bus_err <= fail;
                  bus.cpu_data_ack <= !fail;
                  if (!fail && !wr) bus.cpu_rd_data <= bus.bus_data_in;
               end
            end
            DONE: begin
               state <= RECOVER;
               cnt <= '0;
               bus.R_Wn <= 1'b1;
               bus.bus_data_oe <= 1'b0;
            end
            RECOVER: begin
               cnt <= cnt + 1'b1;
               if ((dtack_s && berr_s) || cnt == LAST) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_m68k_bus_sequencer.sv
// tb_m68k_bus_sequencer: randomized and directed bus cycles checked against a cycle-interval reference model
module tb_m68k_bus_sequencer;
   localparam int TO = 16;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   m68k_bus_sequencer_if bus();
   m68k_bus_sequencer #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus));
   int tests = 0;
   int fails = 0;
   logic [15:0] exp_rd = '0;
   logic [6:0] obs [64];
   logic [22:0] obs_addr;
   logic [15:0] obs_dout;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] sample();
      return {bus.ASn, bus.UDSn, bus.LDSn, bus.R_Wn, bus.bus_data_oe, bus.cpu_data_ack, bus.cpu_bus_err};
   endfunction

   // Cycle of the DONE pulse counted from the request cycle (0); responders assert at cycle ta/tb, -1 = never
   function automatic int done_cycle(input logic [1:0] be, input int ta, input int tb, output logic err);
      int first;
      err = 1'b0;
      if (be == 2'b00) return 2;
      first = (ta < 0) ? tb : (tb < 0) ? ta : (ta < tb ? ta : tb);
      if (first < 0 || first + 2 > TO + 1) begin
         err = 1'b1;
         return TO + 2;
      end
      err = tb >= 0 && tb <= first;
      return first + 3;
   endfunction

   // Expected {ASn,UDSn,LDSn,R_Wn,oe,ack,err} in cycle c of a transaction completing in cycle done
   function automatic logic [6:0] expect_at(input int c, input logic wr, input logic [1:0] be, input int done, input logic err);
      int s;
      logic as_l, u_l, l_l, rw, oe;
      s = wr ? 3 : 2;
      as_l = be != 2'b00 && c >= 2 && c < done;
      u_l = be[1] && c >= s && c < done;
      l_l = be[0] && c >= s && c < done;
      rw = !(wr && c >= 1 && c <= done);
      oe = wr && be != 2'b00 && c >= 1 && c <= done;
      return {!as_l, !u_l, !l_l, rw, oe, c == done && !err, c == done && err};
   endfunction

   task automatic run_txn(input logic wr, input logic [1:0] be, input logic [31:0] addr, input logic [15:0] wdata,
                          input logic [15:0] rdata, input int ta, input int tb, input int ncyc, input logic drop);
      logic released;
      released = 1'b0;
      bus.cpu_rd_ena = !wr;
      bus.cpu_wr_ena = wr;
      bus.cpu_byte_ena = be;
      bus.cpu_address = addr;
      bus.cpu_wr_data = wdata;
      bus.bus_data_in = rdata;
      for (int c = 1; c < ncyc; c++) begin
         step();
         obs[c] = sample();
         if (c == 1) begin
            obs_addr = bus.bus_addr;
            obs_dout = bus.bus_data_out;
         end
         if (obs[c][1] || obs[c][0] || (drop && c == 2)) begin
            bus.cpu_rd_ena = 1'b0;
            bus.cpu_wr_ena = 1'b0;
         end
         if (c > 2 && bus.ASn) released = 1'b1;
         bus.DTACKn = !(ta >= 0 && c >= ta && !released);
         bus.BERRn = !(tb >= 0 && c >= tb && !released);
      end
      bus.cpu_rd_ena = 1'b0;
      bus.cpu_wr_ena = 1'b0;
      bus.DTACKn = 1'b1;
      bus.BERRn = 1'b1;
      repeat (4) step();
   endtask

   task automatic test_reset();
      step();
      step();
      tests++;
      if (sample() !== 7'b1111000) begin
         fails++;
         $display("FAIL reset_strobes: got %b want %b", sample(), 7'b1111000);
      end
      tests++;
      if (bus.cpu_rd_data !== 16'h0 || bus.bus_addr !== 23'h0) begin
         fails++;
         $display("FAIL reset_regs: rd_data %h bus_addr %h want 0 0", bus.cpu_rd_data, bus.bus_addr);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_read();
      logic err;
      int done;
      done = done_cycle(2'b11, 2, -1, err);
      run_txn(1'b0, 2'b11, 32'h0000_0400, 16'h0, 16'hBEEF, 2, -1, done + 3, 1'b0);
      for (int c = 1; c <= done + 1; c++) begin
         tests++;
         if (obs[c] !== expect_at(c, 1'b0, 2'b11, done, err)) begin
            fails++;
            $display("FAIL read_wave cycle %0d: got %b want %b", c, obs[c], expect_at(c, 1'b0, 2'b11, done, err));
         end
      end
      exp_rd = 16'hBEEF;
      tests++;
      if (bus.cpu_rd_data !== exp_rd || obs_addr !== 23'h000200) begin
         fails++;
         $display("FAIL read_data: rd_data %h addr %h want %h 000200", bus.cpu_rd_data, obs_addr, exp_rd);
      end
   endtask

   task automatic test_write();
      logic err;
      int done;
      done = done_cycle(2'b01, 3, -1, err);
      run_txn(1'b1, 2'b01, 32'h00FF_0002, 16'h1234, 16'h0, 3, -1, done + 3, 1'b0);
      for (int c = 1; c <= done + 1; c++) begin
         tests++;
         if (obs[c] !== expect_at(c, 1'b1, 2'b01, done, err)) begin
            fails++;
            $display("FAIL write_wave cycle %0d: got %b want %b", c, obs[c], expect_at(c, 1'b1, 2'b01, done, err));
         end
      end
      tests++;
      if (obs_dout !== 16'h1234 || obs_addr !== 23'h7F8001 || bus.cpu_rd_data !== exp_rd) begin
         fails++;
         $display("FAIL write_bus: dout %h addr %h rd %h want 1234 7f8001 %h", obs_dout, obs_addr, bus.cpu_rd_data, exp_rd);
      end
   endtask

   task automatic test_timeout();
      logic err;
      int done;
      done = done_cycle(2'b10, -1, -1, err);
      run_txn(1'b0, 2'b10, $urandom, 16'h0, 16'hDEAD, -1, -1, done + 3, 1'b0);
      for (int c = 1; c <= done + 1; c++) begin
         tests++;
         if (obs[c] !== expect_at(c, 1'b0, 2'b10, done, err)) begin
            fails++;
            $display("FAIL timeout_wave cycle %0d: got %b want %b", c, obs[c], expect_at(c, 1'b0, 2'b10, done, err));
         end
      end
      tests++;
      if (bus.cpu_rd_data !== exp_rd) begin
         fails++;
         $display("FAIL timeout_rd: got %h want %h", bus.cpu_rd_data, exp_rd);
      end
   endtask

   task automatic test_berr_dtack();
      logic err;
      int done;
      done = done_cycle(2'b11, 3, 3, err);
      run_txn(1'b0, 2'b11, $urandom, 16'h0, ~exp_rd, 3, 3, done + 3, 1'b0);
      for (int c = 1; c <= done + 1; c++) begin
         tests++;
         if (obs[c] !== expect_at(c, 1'b0, 2'b11, done, err)) begin
            fails++;
            $display("FAIL berr_wave cycle %0d: got %b want %b", c, obs[c], expect_at(c, 1'b0, 2'b11, done, err));
         end
      end
      tests++;
      if (bus.cpu_rd_data !== exp_rd) begin
         fails++;
         $display("FAIL berr_rd: got %h want %h", bus.cpu_rd_data, exp_rd);
      end
   endtask

   task automatic test_reset_mid();
      logic err;
      int done;
      bus.cpu_wr_ena = 1'b1;
      bus.cpu_byte_ena = 2'b11;
      bus.cpu_address = $urandom;
      bus.cpu_wr_data = 16'($urandom);
      repeat (4) step();
      tests++;
      if (bus.ASn !== 1'b0 || bus.bus_data_oe !== 1'b1) begin
         fails++;
         $display("FAIL mid_pre: ASn %b oe %b want 0 1", bus.ASn, bus.bus_data_oe);
      end
      rst = 1'b1;
      step();
      tests++;
      if ({bus.ASn, bus.UDSn, bus.LDSn, bus.bus_data_oe} !== 4'b1110) begin
         fails++;
         $display("FAIL mid_strobes: ASn/UDSn/LDSn/oe got %b want 1110", {bus.ASn, bus.UDSn, bus.LDSn, bus.bus_data_oe});
      end
      rst = 1'b0;
      bus.cpu_wr_ena = 1'b0;
      exp_rd = '0;
      for (int c = 0; c < 4; c++) begin
         tests++;
         if (bus.cpu_data_ack !== 1'b0 || bus.cpu_bus_err !== 1'b0) begin
            fails++;
            $display("FAIL mid_no_ack: ack %b err %b want 0 0", bus.cpu_data_ack, bus.cpu_bus_err);
         end
         step();
      end
      done = done_cycle(2'b11, 2, -1, err);
      run_txn(1'b0, 2'b11, $urandom, 16'h0, 16'hC0DE, 2, -1, done + 3, 1'b0);
      for (int c = 1; c <= done + 1; c++) begin
         tests++;
         if (obs[c] !== expect_at(c, 1'b0, 2'b11, done, err)) begin
            fails++;
            $display("FAIL mid_after cycle %0d: got %b want %b", c, obs[c], expect_at(c, 1'b0, 2'b11, done, err));
         end
      end
      exp_rd = 16'hC0DE;
      tests++;
      if (bus.cpu_rd_data !== exp_rd) begin
         fails++;
         $display("FAIL mid_rd: got %h want %h", bus.cpu_rd_data, exp_rd);
      end
   endtask

   // DTACKn held low from the start and released in cycle 12; the queued read must wait for it
   task automatic test_zero_be();
      logic [15:0] rdata;
      rdata = 16'h5A5A;
      bus.DTACKn = 1'b0;
      bus.cpu_rd_ena = 1'b1;
      bus.cpu_byte_ena = 2'b00;
      bus.cpu_address = $urandom;
      bus.bus_data_in = rdata;
      for (int c = 1; c <= 24; c++) begin
         step();
         tests++;
         if ((c == 2 || c == 20) ? bus.cpu_data_ack !== 1'b1 : (bus.cpu_data_ack !== 1'b0 || bus.cpu_bus_err !== 1'b0)) begin
            fails++;
            $display("FAIL zero_be_ack cycle %0d: ack %b err %b", c, bus.cpu_data_ack, bus.cpu_bus_err);
         end
         tests++;
         if (bus.ASn !== (c == 17 || c == 18 || c == 19 ? 1'b0 : 1'b1)) begin
            fails++;
            $display("FAIL zero_be_as cycle %0d: got %b", c, bus.ASn);
         end
         if (c == 3) begin
            tests++;
            if (bus.cpu_rd_data !== 16'h0) begin
               fails++;
               $display("FAIL zero_be_rd: got %h want 0000", bus.cpu_rd_data);
            end
         end
         if (c == 2) bus.cpu_byte_ena = 2'b11;
         if (c == 20) bus.cpu_rd_ena = 1'b0;
         bus.DTACKn = !(c < 12 || (c >= 17 && c < 20));
      end
      exp_rd = rdata;
      tests++;
      if (bus.cpu_rd_data !== exp_rd) begin
         fails++;
         $display("FAIL zero_be_next_rd: got %h want %h", bus.cpu_rd_data, exp_rd);
      end
      bus.DTACKn = 1'b1;
      repeat (4) step();
   endtask

   // One-cycle DTACKn pulse per bus cycle gives the minimum 7-cycle period
   task automatic test_back_to_back();
      int acks[$];
      logic prev_as;
      prev_as = 1'b1;
      bus.cpu_rd_ena = 1'b1;
      bus.cpu_byte_ena = 2'b11;
      bus.cpu_address = $urandom;
      bus.bus_data_in = 16'($urandom);
      for (int c = 1; c <= 40; c++) begin
         step();
         if (bus.cpu_data_ack) acks.push_back(c);
         if (acks.size() == 5) bus.cpu_rd_ena = 1'b0;
         bus.DTACKn = !(prev_as && !bus.ASn);
         prev_as = bus.ASn;
      end
      bus.DTACKn = 1'b1;
      tests++;
      if (acks.size() != 5) begin
         fails++;
         $display("FAIL b2b_count: got %0d acks want 5", acks.size());
      end
      for (int k = 0; k < acks.size(); k++) begin
         tests++;
         if (acks[k] != 5 + 7 * k) begin
            fails++;
            $display("FAIL b2b_cycle %0d: ack at %0d want %0d", k, acks[k], 5 + 7 * k);
         end
      end
      exp_rd = bus.bus_data_in;
      tests++;
      if (bus.cpu_rd_data !== exp_rd) begin
         fails++;
         $display("FAIL b2b_rd: got %h want %h", bus.cpu_rd_data, exp_rd);
      end
   endtask

   task automatic test_random();
      logic wr, err, drop;
      logic [1:0] be;
      logic [31:0] addr;
      logic [15:0] wdata, rdata;
      int ta, tb, done;
      for (int i = 0; i < 24; i++) begin
         wr = 1'($urandom_range(0, 1));
         be = 2'($urandom_range(1, 3));
         addr = $urandom;
         wdata = 16'($urandom);
         rdata = 16'($urandom);
         ta = $urandom_range(2, TO + 1);
         tb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, TO + 1)) : -1;
         drop = 1'($urandom_range(0, 1));
         done = done_cycle(be, ta, tb, err);
         run_txn(wr, be, addr, wdata, rdata, ta, tb, done + 3, drop);
         for (int c = 1; c <= done + 1; c++) begin
            tests++;
            if (obs[c] !== expect_at(c, wr, be, done, err)) begin
               fails++;
               $display("FAIL rand%0d_wave cycle %0d: got %b want %b", i, c, obs[c], expect_at(c, wr, be, done, err));
            end
         end
         if (!wr && !err) exp_rd = rdata;
         tests++;
         if (bus.cpu_rd_data !== exp_rd || obs_addr !== addr[23:1] || (wr && obs_dout !== wdata)) begin
            fails++;
            $display("FAIL rand%0d_data: rd %h addr %h dout %h want %h %h %h", i, bus.cpu_rd_data, obs_addr, obs_dout, exp_rd, addr[23:1], wdata);
         end
      end
   endtask

   initial begin
      bus.cpu_rd_ena = 1'b0;
      bus.cpu_wr_ena = 1'b0;
      bus.cpu_byte_ena = 2'b00;
      bus.cpu_address = '0;
      bus.cpu_wr_data = '0;
      bus.bus_data_in = '0;
      bus.DTACKn = 1'b1;
      bus.BERRn = 1'b1;
      test_reset();
      test_read();
      test_write();
      test_timeout();
      test_berr_dtack();
      test_reset_mid();
      test_zero_be();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/m68k_bus_sequencer.md
Name: m68k_bus_sequencer

Overview:
- Converts the j68 core's synchronous request interface (rd_ena/wr_ena, byte_ena, address, data_ack) into a true 68000-style asynchronous bus cycle: ASn, UDSn/LDSn, R_Wn and a tri-state data enable.
- Samples DTACKn and BERRn through synchronisers and bounds every cycle with a watchdog that raises a bus error.
- Sits between cpu_j68 and the m68k glue/SRAM/UART decode, clocked on CLK68000.

Parameters:
- TIMEOUT_CYCLES, 256: maximum cycles spent in STROBE+WAIT or in RECOVER before forced completion.
- SYNC_STAGES, 2: flop depth of the DTACKn/BERRn synchronisers (minimum 2).

Ports:
- clk  in  1  CLK68000 domain clock
- rst  in  1  synchronous, active-high reset
- cpu_rd_ena  in  1  read request, held until ack/err
- cpu_wr_ena  in  1  write request, held until ack/err
- cpu_byte_ena  in  2  {upper, lower} byte enables
- cpu_address  in  32  byte address; bits [23:1] are used
- cpu_wr_data  in  16  write data
- cpu_rd_data  out  16  registered read data
- cpu_data_ack  out  1  one-cycle completion pulse
- cpu_bus_err  out  1  one-cycle error pulse, replaces ack
- bus_addr  out  23  address[23:1]
- bus_data_out  out  16  write data to the pad
- bus_data_oe  out  1  1 = drive data bus (write cycles)
- bus_data_in  in  16  data bus sample
- ASn  out  1  address strobe, active low
- R_Wn  out  1  1 = read
- UDSn  out  1  upper data strobe, active low
- LDSn  out  1  lower data strobe, active low
- DTACKn  in  1  asynchronous transfer acknowledge
- BERRn  in  1  asynchronous bus error

Behaviour:
- Reset values: ASn = UDSn = LDSn = R_Wn = 1; bus_data_oe = 0; cpu_data_ack = cpu_bus_err = 0; cpu_rd_data = 0; bus_addr = 0; state = IDLE. Reset mid-cycle negates all strobes at the next edge, and no ack is issued.
- Synchronisers: dtack_s and berr_s are the SYNC_STAGES-deep synchronised versions of DTACKn/BERRn. Their flops reset to 1.
- IDLE: on rd_ena|wr_ena, latch address, byte_ena, wr_data and direction, then go to ADDR. If both are asserted, the cycle is a write.
- byte_ena == 00: no bus cycle; go to DONE with ack; cpu_rd_data = 0.
- ADDR (1 cycle): bus_addr and R_Wn valid. For a write, bus_data_oe = 1. Strobes stay high.
- STROBE (1 cycle): ASn = 0. A read also asserts UDSn/LDSn from byte_ena. The watchdog counter is cleared here.
- WAIT: ASn held low. A write asserts its data strobes on entry, one cycle after ASn. The counter increments every cycle.
  - berr_s == 0 → DONE with error.
  - else dtack_s == 0 → capture bus_data_in into cpu_rd_data (reads only) → DONE with ack.
  - else counter == TIMEOUT_CYCLES-1 → DONE with error.
  - BERR takes priority over a simultaneous DTACK.
- DONE (1 cycle): ASn, UDSn, LDSn = 1. Exactly one of cpu_data_ack or cpu_bus_err is high. bus_data_oe stays 1 for a write (data hold). R_Wn returns to 1 on exit.
- RECOVER: bus_data_oe = 0. Wait for dtack_s == 1 and berr_s == 1, for at least 1 cycle and at most TIMEOUT_CYCLES; on timeout return to IDLE silently. A new request is accepted only in IDLE.
- A request dropped mid-cycle does not abort the bus cycle; ack/err is still pulsed.
- Latency: request sampled at the end of cycle 0. ASn falls in cycle 2. A responder driving DTACKn low during cycle 2 yields cpu_data_ack in cycle 5 with SYNC_STAGES = 2. Minimum back-to-back period is 7 cycles.

Decomposition:
- Package m68k_bus_pkg: state enumeration (IDLE, ADDR, STROBE, WAIT, DONE, RECOVER), strobe-negated constant, timeout counter width = clog2(TIMEOUT_CYCLES).
- Sub-module: reuse the existing sync module for the DTACKn/BERRn synchronisers. The FSM and counter stay in m68k_bus_sequencer.

Test Plan:
- Read, byte_ena = 11, addr 0x000400, responder drives DTACKn low when ASn falls with data 0xBEEF → ASn low in cycles 2–4, UDSn = LDSn = 0 in cycle 2; ack in cycle 5; cpu_rd_data = 0xBEEF; bus_data_oe never 1.
- Write, byte_ena = 01, data 0x1234, addr 0xFF0002 → R_Wn = 0 from cycle 1; ASn low in cycle 2; LDSn low from cycle 3, UDSn stays 1; bus_data_oe high cycles 1–DONE; single ack pulse.
- No responder → cpu_bus_err pulses once after TIMEOUT_CYCLES cycles in STROBE+WAIT; no cpu_data_ack; strobes negated in DONE.
- BERRn and DTACKn asserted in the same cycle → cpu_bus_err = 1, cpu_data_ack = 0, cpu_rd_data unchanged.
- rst asserted during WAIT → next edge ASn = UDSn = LDSn = 1, bus_data_oe = 0, no ack; a new read afterwards completes normally.
- byte_ena = 00 read → no ASn activity; ack in cycle 2; cpu_rd_data = 0. A held DTACKn low delays the next IDLE until it is released.
